// File: rtl/master_slave_link.sv
// master_slave_link: input FIFO feeding a master that moves each word over a
// 4-phase req/ack link to a slave, which holds it in an output register until
// the consumer takes it. Single clock domain.
//
// Handshake semantics (both stream ports): a word moves on a rising edge where
// valid && ready are both high. A producer keeps valid and its data stable
// until that edge. ready never depends combinationally on valid.
module master_slave_link #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, RELEASE = 2'd2} m_state_t;
  typedef enum logic       {S_IDLE = 1'b0, S_ACK = 1'b1} s_state_t;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              push, pop, fifo_empty, fifo_full;

  // Internal link, visible to probes
  logic              link_req, link_ack;
  logic [DATA_W-1:0] link_data;

  // FSM state, visible to probes
  m_state_t m_state, m_next;
  s_state_t s_state, s_next;
  logic     req_d, ack_d, load;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign in_ready   = !fifo_full;
  assign push       = in_valid && in_ready;

  // FIFO storage: data only, no reset needed since count gates reads
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Master next-state: pop a word onto the link, wait for ack, wait for release
  always_comb begin
    m_next = m_state;
    pop    = 1'b0;
    req_d  = link_req;
    case (m_state)
      IDLE: begin
        if (!fifo_empty) begin
          pop    = 1'b1;
          req_d  = 1'b1;
          m_next = SEND;
        end
      end
      SEND: begin
        if (link_ack) begin
          req_d  = 1'b0;
          m_next = RELEASE;
        end
      end
      RELEASE: begin
        if (!link_ack) begin
          if (!fifo_empty) begin
            pop    = 1'b1;
            req_d  = 1'b1;
            m_next = SEND;
          end else begin
            m_next = IDLE;
          end
        end
      end
      default: m_next = IDLE;
    endcase
  end

  // Master registers: state, req, and link_data captured only on pop so it
  // stays stable for the whole time req is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state   <= IDLE;
      link_req  <= 1'b0;
      link_data <= '0;
    end else begin
      m_state  <= m_next;
      link_req <= req_d;
      if (pop) link_data <= mem[rd_ptr];
    end
  end

  // Slave next-state: accept a word only when the output register is free
  always_comb begin
    s_next = s_state;
    ack_d  = link_ack;
    load   = 1'b0;
    case (s_state)
      S_IDLE: begin
        if (link_req && (!out_valid || out_ready)) begin
          load   = 1'b1;
          ack_d  = 1'b1;
          s_next = S_ACK;
        end
      end
      S_ACK: begin
        if (!link_req) begin
          ack_d  = 1'b0;
          s_next = S_IDLE;
        end
      end
      default: s_next = S_IDLE;
    endcase
  end

  // Slave registers: state, ack, output word; a load wins over a consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_state   <= S_IDLE;
      link_ack  <= 1'b0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else begin
      s_state  <= s_next;
      link_ack <= ack_d;
      if (load) begin
        data_out  <= link_data;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_master_slave_link.sv
// Directed bench for master_slave_link: reset, single word latency, streaming
// with FIFO stall, backpressure, full-boundary push/pop, mid-transfer reset.
module tb_master_slave_link;

  localparam int W = 8;

  // Clock / reset
  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] data_in, data_out;

  always #5 clk = ~clk;

  master_slave_link #(.DATA_W(W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );

  // Scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           got_t[$];
  int           cyc = 0;
  int           total = 0;
  int           passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle: capture any output handshake on the coming edge, then step to
  // just after the edge
  task automatic tick();
    if (rst_n && out_valid && out_ready) begin
      got_q.push_back(data_out);
      got_t.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Driver: present one word until accepted or budget runs out
  task automatic send_word(input logic [W-1:0] d, input int budget, output bit acc);
    logic r;
    acc      = 1'b0;
    in_valid = 1'b1;
    data_in  = d;
    for (int k = 0; k < budget; k++) begin
      r = in_ready;
      tick();
      if (r) begin
        acc = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic compare_queues(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_data"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
    got_t.delete();
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit saw_stall;
    int n_acc;

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_link_req", dut.link_req, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_out_valid", out_valid, 1'b0);
    end
    check("idle_link_req", dut.link_req, 1'b0);

    // Single word: link_req one edge after acceptance, output two edges after
    send_word(8'hA5, 4, acc);
    check("single_accept", acc, 1'b1);
    check("single_w0_valid", out_valid, 1'b0);
    tick();
    check("single_w1_req", dut.link_req, 1'b1);
    check("single_w1_valid", out_valid, 1'b0);
    tick();
    check("single_w2_valid", out_valid, 1'b1);
    check("single_w2_data", data_out, 8'hA5);
    tick();
    check("single_w3_valid", out_valid, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    got_q.delete(); got_t.delete();

    // Stream 0x01..0x10 back to back
    saw_stall = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      data_in  = W'(i);
      acc      = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (!in_ready) saw_stall = 1'b1;
        if (in_ready) begin
          tick();
          acc = 1'b1;
          break;
        end
        tick();
      end
      check("stream_accept", acc, 1'b1);
      exp_q.push_back(W'(i));
    end
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    check("stream_saw_stall", saw_stall, 1'b1);
    for (int i = 1; i < got_t.size(); i++)
      check("stream_spacing", got_t[i] - got_t[i-1], 4);
    compare_queues("stream");

    // Backpressure: 8 offered, 6 accepted
    out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      send_word(8'h80 + W'(i), 12, acc);
      if (acc) n_acc++;
    end
    check("bp_accepted", n_acc, 6);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_data_out", data_out, 8'h80);
    check("bp_link_req", dut.link_req, 1'b1);
    check("bp_fifo_count", dut.count, 4);
    for (int i = 0; i < 6; i++) exp_q.push_back(8'h80 + W'(i));
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    compare_queues("bp_drain");

    // Full boundary: FIFO at 3, master pops while producer writes
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_word(8'h90 + W'(i), 12, acc);
      check("fb_accept", acc, 1'b1);
    end
    for (int i = 0; i < 5; i++) tick();
    check("fb_pre_count", dut.count, 3);
    check("fb_pre_link_req", dut.link_req, 1'b1);
    check("fb_pre_in_ready", in_ready, 1'b1);
    check("fb_pre_data_out", data_out, 8'h90);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h90 + W'(i));
    out_ready = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b1;
    data_in  = 8'h55;
    check("fb_pop_now", dut.pop, 1'b1);
    check("fb_in_ready_before", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    exp_q.push_back(8'h55);
    check("fb_post_count", dut.count, 3);
    check("fb_post_in_ready", in_ready, 1'b1);
    for (int i = 0; i < 40; i++) tick();
    compare_queues("fb_drain");

    // Mid-transfer reset with req high and two words queued
    in_valid = 1'b1;
    data_in = 8'h11; tick();
    data_in = 8'h22; tick();
    data_in = 8'h33; tick();
    in_valid = 1'b0;
    check("mr_pre_link_req", dut.link_req, 1'b1);
    check("mr_pre_count", dut.count, 2);
    rst_n = 1'b0;
    #1;
    check("mr_out_valid", out_valid, 1'b0);
    check("mr_data_out", data_out, 8'h00);
    check("mr_link_req", dut.link_req, 1'b0);
    check("mr_link_ack", dut.link_ack, 1'b0);
    check("mr_link_data", dut.link_data, 8'h00);
    check("mr_count", dut.count, 0);
    check("mr_in_ready", in_ready, 1'b1);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_quiet_valid", out_valid, 1'b0);
    end
    send_word(8'h3C, 4, acc);
    check("mr_new_accept", acc, 1'b1);
    tick();
    check("mr_new_w1_valid", out_valid, 1'b0);
    tick();
    check("mr_new_w2_valid", out_valid, 1'b1);
    check("mr_new_w2_data", data_out, 8'h3C);
    tick();
    check("mr_new_w3_valid", out_valid, 1'b0);
    got_q.delete(); got_t.delete();

    // Final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
